// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
//   Brings a PLL out of reset, waits for lock, requires the lock to hold
//   steadily for a settle window, then releases the core-domain reset and
//   flags ready. Lock loss while running restarts the sequence. A lock wait
//   that times out restarts it too, up to a bounded number of attempts,
//   after which the block parks in FAIL until relock_req or rst.
//
// Ports
//   refclk      in   free-running reference clock, the only clock
//   rst         in   asynchronous active-high reset
//   pll_locked  in   PLL lock flag, asynchronous to refclk
//   relock_req  in   single-cycle request to restart from any state
//   pll_rst     out  PLL reset, high only in RESET_PLL
//   core_rst    out  downstream reset, low only in RUN
//   ready       out  high only in RUN
//   fail        out  high only in FAIL
//   state_o     out  current state (0 RESET_PLL .. 4 FAIL)
//   retry_cnt   out  failed lock attempts since the last RUN
//   loss_cnt    out  lock-loss events seen in RUN, saturating, cleared by rst

module pll_lock_sequencer #(
    parameter int RST_CYCLES     = 16,
    parameter int TIMEOUT_CYCLES = 74250,
    parameter int SETTLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 7,
    parameter int SYNC_STAGES    = 2,
    parameter int CNT_W          = 20
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_rst,
    output logic       ready,
    output logic       fail,
    output logic [2:0] state_o,
    output logic [2:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        SETTLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       MAX_R       = 3'(MAX_RETRIES);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       timer_q, timer_d;
    logic [2:0]             retry_q, retry_d;
    logic [7:0]             loss_q, loss_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lk;

    logic pll_rst_q, pll_rst_d;
    logic core_rst_q, core_rst_d;
    logic ready_q, ready_d;
    logic fail_q, fail_d;

    // pll_locked is asynchronous; every decision uses the last sync stage.
    assign lk = sync_q[SYNC_STAGES-1];

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_PLL;
            timer_q    <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            sync_q     <= '0;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            pll_rst_q  <= pll_rst_d;
            core_rst_q <= core_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    // Next-state logic. One shared timer serves every timed state; it is
    // zeroed on each transition so every state starts counting from 0.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        case (state_q)
            RESET_PLL: begin
                if (timer_q == RST_LAST) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                // Lock takes precedence over a coincident timeout.
                if (lk) begin
                    state_d = SETTLE;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    timer_d = '0;
                    if (retry_q < MAX_R) begin
                        state_d = RESET_PLL;
                        if (retry_q != 3'd7) retry_d = retry_q + 3'd1;
                    end else begin
                        state_d = FAIL;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                // A bounce restarts the lock wait without costing a retry.
                if (!lk) begin
                    state_d = WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = RUN;
                    timer_d = '0;
                    retry_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d = RESET_PLL;
                    timer_d = '0;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            FAIL: begin
            end
            default: begin
                state_d = RESET_PLL;
                timer_d = '0;
            end
        endcase
        // relock_req overrides the destination; a coincident RUN lock loss
        // has already been counted above.
        if (relock_req) begin
            state_d = RESET_PLL;
            timer_d = '0;
            retry_d = '0;
        end
    end

    // Output decode of the next state, so the registered outputs always
    // match the state they are registered alongside.
    always_comb begin
        pll_rst_d  = (state_d == RESET_PLL);
        core_rst_d = (state_d != RUN);
        ready_d    = (state_d == RUN);
        fail_d     = (state_d == FAIL);
    end

    assign pll_rst   = pll_rst_q;
    assign core_rst  = core_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign state_o   = state_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timing parameters.
module tb_pll_lock_sequencer;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_rst;
    logic       core_rst;
    logic       ready;
    logic       fail;
    logic [2:0] state_o;
    logic [2:0] retry_cnt;
    logic [7:0] loss_cnt;

    int ncmp = 0;
    int nbad = 0;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .TIMEOUT_CYCLES(100),
        .SETTLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .SYNC_STAGES   (2),
        .CNT_W         (20)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .core_rst  (core_rst),
        .ready     (ready),
        .fail      (fail),
        .state_o   (state_o),
        .retry_cnt (retry_cnt),
        .loss_cnt  (loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    typedef struct {
        logic       lk;
        logic       rq;
        int         n;
        logic [2:0] st;
        logic [2:0] rc;
        logic [7:0] lc;
    } vec_t;

    vec_t tbl[17];

    // {pll_rst, core_rst, ready, fail, state, retry, loss}
    function automatic logic [17:0] outv();
        return {pll_rst, core_rst, ready, fail, state_o, retry_cnt, loss_cnt};
    endfunction

    function automatic logic [17:0] expv(logic [2:0] st, logic [2:0] rc, logic [7:0] lc);
        return {st == 3'd0, st != 3'd3, st == 3'd3, st == 3'd4, st, rc, lc};
    endfunction

    task automatic tick(int n);
        for (int k = 0; k < n; k++) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic chk(string nm, logic [17:0] exp);
        logic [17:0] act;
        act = outv();
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        int bad_hold;
        // Nominal bring-up followed by a lock loss in RUN and relock.
        tbl[0]  = '{1'b0, 1'b0, 0, 3'd0, 3'd0, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 3, 3'd0, 3'd0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1, 3'd1, 3'd0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 5, 3'd1, 3'd0, 8'd0};
        tbl[4]  = '{1'b1, 1'b0, 2, 3'd1, 3'd0, 8'd0};
        tbl[5]  = '{1'b1, 1'b0, 1, 3'd2, 3'd0, 8'd0};
        tbl[6]  = '{1'b1, 1'b0, 7, 3'd2, 3'd0, 8'd0};
        tbl[7]  = '{1'b1, 1'b0, 1, 3'd3, 3'd0, 8'd0};
        tbl[8]  = '{1'b1, 1'b0, 5, 3'd3, 3'd0, 8'd0};
        tbl[9]  = '{1'b0, 1'b0, 2, 3'd3, 3'd0, 8'd0};
        tbl[10] = '{1'b0, 1'b0, 1, 3'd0, 3'd0, 8'd1};
        tbl[11] = '{1'b0, 1'b0, 3, 3'd0, 3'd0, 8'd1};
        tbl[12] = '{1'b0, 1'b0, 1, 3'd1, 3'd0, 8'd1};
        tbl[13] = '{1'b1, 1'b0, 2, 3'd1, 3'd0, 8'd1};
        tbl[14] = '{1'b1, 1'b0, 1, 3'd2, 3'd0, 8'd1};
        tbl[15] = '{1'b1, 1'b0, 7, 3'd2, 3'd0, 8'd1};
        tbl[16] = '{1'b1, 1'b0, 1, 3'd3, 3'd0, 8'd1};

        rst = 1'b1;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        tick(2);
        chk("reset_state", expv(3'd0, 3'd0, 8'd0));
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            pll_locked = tbl[i].lk;
            relock_req = tbl[i].rq;
            tick(tbl[i].n);
            chk($sformatf("vec%0d", i), expv(tbl[i].st, tbl[i].rc, tbl[i].lc));
        end

        // Restart from RUN, then bounce the lock late in the settle window.
        relock_req = 1'b1;
        tick(1);
        chk("relock_run", expv(3'd0, 3'd0, 8'd1));
        relock_req = 1'b0;
        tick(4);
        chk("re_wait", expv(3'd1, 3'd0, 8'd1));
        tick(1);
        chk("re_settle", expv(3'd2, 3'd0, 8'd1));
        tick(5);
        pll_locked = 1'b0;
        tick(2);
        chk("bounce_late", expv(3'd2, 3'd0, 8'd1));
        tick(1);
        chk("bounce_wait", expv(3'd1, 3'd0, 8'd1));
        pll_locked = 1'b1;
        tick(2);
        chk("bounce_hold", expv(3'd1, 3'd0, 8'd1));
        tick(1);
        chk("bounce_resettle", expv(3'd2, 3'd0, 8'd1));
        tick(7);
        chk("bounce_settle7", expv(3'd2, 3'd0, 8'd1));
        tick(1);
        chk("bounce_run", expv(3'd3, 3'd0, 8'd1));

        // lk fall coincides with relock_req in RUN.
        pll_locked = 1'b0;
        tick(2);
        chk("coinc_pre", expv(3'd3, 3'd0, 8'd1));
        relock_req = 1'b1;
        tick(1);
        chk("coinc_relock", expv(3'd0, 3'd0, 8'd2));
        relock_req = 1'b0;

        // Lock never arrives: two retries then FAIL.
        tick(4);
        chk("nl_wait0", expv(3'd1, 3'd0, 8'd2));
        tick(99);
        chk("nl_wait0_end", expv(3'd1, 3'd0, 8'd2));
        tick(1);
        chk("nl_retry1", expv(3'd0, 3'd1, 8'd2));
        tick(3);
        chk("nl_rst1_end", expv(3'd0, 3'd1, 8'd2));
        tick(1);
        chk("nl_wait1", expv(3'd1, 3'd1, 8'd2));
        tick(99);
        chk("nl_wait1_end", expv(3'd1, 3'd1, 8'd2));
        tick(1);
        chk("nl_retry2", expv(3'd0, 3'd2, 8'd2));
        tick(4);
        chk("nl_wait2", expv(3'd1, 3'd2, 8'd2));
        tick(99);
        chk("nl_wait2_end", expv(3'd1, 3'd2, 8'd2));
        tick(1);
        chk("nl_fail", expv(3'd4, 3'd2, 8'd2));
        bad_hold = 0;
        for (int c = 0; c < 500; c++) begin
            tick(1);
            if (outv() !== expv(3'd4, 3'd2, 8'd2)) bad_hold++;
        end
        ncmp++;
        if (bad_hold != 0) begin
            nbad++;
            $display("FAIL fail_hold: %0d cycles left FAIL, expected 0", bad_hold);
        end

        // Recovery from FAIL.
        relock_req = 1'b1;
        tick(1);
        chk("fail_relock", expv(3'd0, 3'd0, 8'd2));
        relock_req = 1'b0;
        pll_locked = 1'b1;
        tick(4);
        chk("rec_wait", expv(3'd1, 3'd0, 8'd2));
        tick(1);
        chk("rec_settle", expv(3'd2, 3'd0, 8'd2));
        tick(2);

        // Asynchronous reset between clock edges, mid-SETTLE.
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", expv(3'd0, 3'd0, 8'd0));
        tick(1);
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
